// File: rtl/parking_lot_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : parking_lot_fsm
// Description : Direction-sensing A/B beam sequencer with saturating occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_lot_fsm #(
    parameter int CAPACITY = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_a,
    input  logic             sensor_b,
    output logic             car_in,
    output logic             car_out,
    output logic             count_err,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             seq_err
);

    localparam logic [CNT_W-1:0] C_CAP  = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENT_A  = 3'd1,
        S_ENT_AB = 3'd2,
        S_ENT_B  = 3'd3,
        S_EXT_B  = 3'd4,
        S_EXT_BA = 3'd5,
        S_EXT_A  = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_occ;
    logic             r_car_in;
    logic             r_car_out;
    logic             r_count_err;
    logic [1:0]       w_ab;

    assign w_ab = {sensor_a, sensor_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_occ       <= C_ZERO;
            r_car_in    <= 1'b0;
            r_car_out   <= 1'b0;
            r_count_err <= 1'b0;
        end else begin
            r_car_in    <= 1'b0;
            r_car_out   <= 1'b0;
            r_count_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    case (w_ab)
                        2'b10:   r_state <= S_ENT_A;
                        2'b01:   r_state <= S_EXT_B;
                        2'b11:   r_state <= S_ERR;
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_ENT_A: begin
                    case (w_ab)
                        2'b11:   r_state <= S_ENT_AB;
                        2'b00:   r_state <= S_IDLE;
                        2'b01:   r_state <= S_ERR;
                        default: r_state <= S_ENT_A;
                    endcase
                end
                S_ENT_AB: begin
                    case (w_ab)
                        2'b01:   r_state <= S_ENT_B;
                        2'b10:   r_state <= S_ENT_A;
                        2'b00:   r_state <= S_ERR;
                        default: r_state <= S_ENT_AB;
                    endcase
                end
                S_ENT_B: begin
                    case (w_ab)
                        2'b11:   r_state <= S_ENT_AB;
                        2'b10:   r_state <= S_ERR;
                        2'b00: begin
                            r_state <= S_IDLE;
                            // A full lot refuses the entry rather than wrapping the count
                            if (r_occ < C_CAP) begin
                                r_occ    <= r_occ + C_ONE;
                                r_car_in <= 1'b1;
                            end else begin
                                r_count_err <= 1'b1;
                            end
                        end
                        default: r_state <= S_ENT_B;
                    endcase
                end
                S_EXT_B: begin
                    case (w_ab)
                        2'b11:   r_state <= S_EXT_BA;
                        2'b00:   r_state <= S_IDLE;
                        2'b10:   r_state <= S_ERR;
                        default: r_state <= S_EXT_B;
                    endcase
                end
                S_EXT_BA: begin
                    case (w_ab)
                        2'b10:   r_state <= S_EXT_A;
                        2'b01:   r_state <= S_EXT_B;
                        2'b00:   r_state <= S_ERR;
                        default: r_state <= S_EXT_BA;
                    endcase
                end
                S_EXT_A: begin
                    case (w_ab)
                        2'b11:   r_state <= S_EXT_BA;
                        2'b01:   r_state <= S_ERR;
                        2'b00: begin
                            r_state <= S_IDLE;
                            if (r_occ != C_ZERO) begin
                                r_occ     <= r_occ - C_ONE;
                                r_car_out <= 1'b1;
                            end else begin
                                r_count_err <= 1'b1;
                            end
                        end
                        default: r_state <= S_EXT_A;
                    endcase
                end
                S_ERR: begin
                    if (w_ab == 2'b00) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign car_in    = r_car_in;
    assign car_out   = r_car_out;
    assign count_err = r_count_err;
    assign occupancy = r_occ;
    assign full      = (r_occ == C_CAP);
    assign empty     = (r_occ == C_ZERO);
    assign seq_err   = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_parking_lot_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_parking_lot_fsm
// Description : Table, directed and randomized checks of parking_lot_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_lot_fsm;

    localparam int CAPACITY = 15;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sensor_a;
    logic             sensor_b;
    logic             w_car_in;
    logic             w_car_out;
    logic             w_count_err;
    logic [CNT_W-1:0] w_occupancy;
    logic             w_full;
    logic             w_empty;
    logic             w_seq_err;

    int n_vec  = 0;
    int n_miss = 0;

    parking_lot_fsm #(.CAPACITY(CAPACITY), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .car_in    (w_car_in),
        .car_out   (w_car_out),
        .count_err (w_count_err),
        .occupancy (w_occupancy),
        .full      (w_full),
        .empty     (w_empty),
        .seq_err   (w_seq_err)
    );

    always #5 clk = ~clk;

    // Reference: a passage is a walk of single-bit steps; its direction is fixed
    // by the first beam broken, and it counts only if the far beam was last.
    bit       m_busy, m_entry, m_err;
    bit [1:0] m_last;
    int       m_occ;
    bit       m_in, m_out, m_cerr;

    function automatic void model_reset();
        m_busy = 0; m_entry = 0; m_err = 0; m_last = 2'b00;
        m_occ  = 0; m_in = 0; m_out = 0; m_cerr = 0;
    endfunction

    function automatic void model_step(bit [1:0] ab);
        m_in = 0; m_out = 0; m_cerr = 0;
        if (m_err) begin
            if (ab == 2'b00) m_err = 0;
        end else if (!m_busy) begin
            if (ab == 2'b11) m_err = 1;
            else if (ab != 2'b00) begin
                m_busy = 1; m_entry = (ab == 2'b10); m_last = ab;
            end
        end else if ((ab ^ m_last) == 2'b11) begin
            m_busy = 0; m_err = 1;
        end else if (ab == 2'b00) begin
            m_busy = 0;
            if (m_last == (m_entry ? 2'b01 : 2'b10)) begin
                if (m_entry) begin
                    if (m_occ < CAPACITY) begin m_occ++; m_in = 1; end
                    else m_cerr = 1;
                end else begin
                    if (m_occ > 0) begin m_occ--; m_out = 1; end
                    else m_cerr = 1;
                end
            end
        end else begin
            m_last = ab;
        end
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, bit ci, bit co, bit ce, bit se, int occ);
        chk({tag, " car_in"},    32'(w_car_in),    32'(ci));
        chk({tag, " car_out"},   32'(w_car_out),   32'(co));
        chk({tag, " count_err"}, 32'(w_count_err), 32'(ce));
        chk({tag, " seq_err"},   32'(w_seq_err),   32'(se));
        chk({tag, " occupancy"}, 32'(w_occupancy), 32'(occ));
        chk({tag, " full"},      32'(w_full),      32'(occ == CAPACITY));
        chk({tag, " empty"},     32'(w_empty),     32'(occ == 0));
    endtask

    task automatic edge_drive(bit [1:0] ab);
        @(negedge clk);
        {sensor_a, sensor_b} = ab;
        @(posedge clk);
        #1;
        model_step(ab);
    endtask

    task automatic step(bit [1:0] ab, string tag);
        edge_drive(ab);
        chk_all(tag, m_in, m_out, m_cerr, m_err, m_occ);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        {sensor_a, sensor_b} = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_all("reset", 0, 0, 0, 0, 0);
    endtask

    task automatic do_entry(string tag);
        step(2'b10, tag); step(2'b11, tag); step(2'b01, tag); step(2'b00, tag);
    endtask

    typedef struct {
        logic [1:0] ab;
        logic       car_in;
        logic       car_out;
        logic       count_err;
        logic       seq_err;
        int         occ;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [1:0] ab, logic ci, logic co, logic ce, logic se, int occ);
        vec_t v;
        v.ab = ab; v.car_in = ci; v.car_out = co; v.count_err = ce; v.seq_err = se; v.occ = occ;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {sensor_a, sensor_b} = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("por", 0, 0, 0, 0, 0);

        // Entry with 3-cycle holds, pulse lasts one cycle
        add(2'b00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(2'b10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(2'b11, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(2'b01, 0, 0, 0, 0, 0);
        add(2'b00, 1, 0, 0, 0, 1);
        add(2'b00, 0, 0, 0, 0, 1);
        // Reversal inside entry, then exit aborted at the inner beam
        add(2'b10, 0, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 0, 1); add(2'b10, 0, 0, 0, 0, 1);
        add(2'b11, 0, 0, 0, 0, 1); add(2'b01, 0, 0, 0, 0, 1); add(2'b00, 1, 0, 0, 0, 2);
        add(2'b01, 0, 0, 0, 0, 2); add(2'b11, 0, 0, 0, 0, 2); add(2'b01, 0, 0, 0, 0, 2);
        add(2'b00, 0, 0, 0, 0, 2);
        // Exit and aborted entry
        add(2'b01, 0, 0, 0, 0, 2); add(2'b11, 0, 0, 0, 0, 2); add(2'b10, 0, 0, 0, 0, 2);
        add(2'b00, 0, 1, 0, 0, 1);
        add(2'b10, 0, 0, 0, 0, 1); add(2'b00, 0, 0, 0, 0, 1);
        // Illegal jump 11->00, ERR holds until 00
        add(2'b10, 0, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 0, 1); add(2'b00, 0, 0, 0, 1, 1);
        add(2'b11, 0, 0, 0, 1, 1); add(2'b00, 0, 0, 0, 0, 1);
        add(2'b11, 0, 0, 0, 1, 1); add(2'b10, 0, 0, 0, 1, 1); add(2'b00, 0, 0, 0, 0, 1);
        // Exit to empty, then exit from empty is refused
        add(2'b01, 0, 0, 0, 0, 1); add(2'b11, 0, 0, 0, 0, 1); add(2'b10, 0, 0, 0, 0, 1);
        add(2'b00, 0, 1, 0, 0, 0);
        add(2'b01, 0, 0, 0, 0, 0); add(2'b11, 0, 0, 0, 0, 0); add(2'b10, 0, 0, 0, 0, 0);
        add(2'b00, 0, 0, 1, 0, 0);
        add(2'b00, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            edge_drive(tbl[i].ab);
            chk_all($sformatf("tbl[%0d]", i), tbl[i].car_in, tbl[i].car_out,
                    tbl[i].count_err, tbl[i].seq_err, tbl[i].occ);
        end

        // Fill to capacity, then a refused 16th entry
        reset_dut();
        for (int i = 0; i < CAPACITY; i++) do_entry("fill");
        chk("full after fill", 32'(w_full), 32'd1);
        step(2'b10, "over"); step(2'b11, "over"); step(2'b01, "over");
        edge_drive(2'b00);
        chk_all("16th entry", 0, 0, 1, 0, 15);
        edge_drive(2'b00);
        chk_all("after 16th", 0, 0, 0, 0, 15);

        // Asynchronous reset between edges while in ENT_AB
        reset_dut();
        for (int i = 0; i < 5; i++) do_entry("pre5");
        step(2'b10, "pre_rst");
        edge_drive(2'b11);
        chk_all("ent_ab occ5", 0, 0, 0, 0, 5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        {sensor_a, sensor_b} = 2'b00;
        #1;
        chk_all("async rst", 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        edge_drive(2'b01);
        chk_all("post rst 01", 0, 0, 0, 0, 0);
        edge_drive(2'b00);
        chk_all("post rst 00", 0, 0, 0, 0, 0);

        // Randomized walk, mostly single-beam changes
        reset_dut();
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            bit [1:0] ab;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                reset_dut();
            end else begin
                ab = {sensor_a, sensor_b};
                if (r < 180) begin
                    case ($urandom_range(0, 2))
                        0:       ab = ab;
                        1:       ab[1] = ~ab[1];
                        default: ab[0] = ~ab[0];
                    endcase
                end else begin
                    ab = 2'($urandom_range(0, 3));
                end
                step(ab, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
